pico_dma_master: RTL and testbench
==================================

# pico_dma_master

Word-granular DMA engine that acts as a second initiator on the PicoRV32 native memory interface (mem_valid / mem_ready / mem_addr / mem_wdata / mem_wstrb / mem_rdata). It accepts a copy command on a valid/ready command port, then drives single-word reads from a source region and writes to a destination region. Each transfer follows the same handshake the on-chip memory responder serves. It sits beside the core in the SoC top, muxed onto the memory port, and reports completion, busy and error status.

## Interface
- TIMEOUT, 256: cycles mem_valid may stay high without mem_ready before abort; must be ≥ 2.
- LEN_W, 16: width of the word-count field.
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_src  in  32  source byte address; word aligned.
- cmd_dst  in  32  destination byte address; word aligned.
- cmd_len  in  LEN_W  number of 32-bit words.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse, for success and error.
- err  out  2  00 ok, 01 misaligned, 10 timeout; held until next accept.
- mem_valid  out  1  request valid.
- mem_instr  out  1  constant 0.
- mem_ready  in  1  responder completion.
- mem_addr  out  32  request address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  0000 = read, 1111 = write.
- mem_rdata  in  32  read data; valid only in the mem_ready cycle.

## Operation
- States: IDLE, RD, WR, FIN.
- Accept: cmd_valid && cmd_ready at a rising edge. On accept, latch src, dst and len, and clear err.
- Accept from IDLE:
  - if cmd_src[1:0] or cmd_dst[1:0] is nonzero: go to FIN, set err = 01, no bus activity.
  - else if len = 0: go to FIN, err = 00.
  - else: go to RD.
- RD:
  - mem_valid = 1, mem_addr = src, mem_wstrb = 0.
  - On mem_ready: capture mem_rdata, src += 4, go to WR.
- WR:
  - mem_valid = 1, mem_addr = dst, mem_wstrb = 1111, mem_wdata = captured word.
  - On mem_ready: dst += 4, len -= 1.
  - If the new len = 0, go to FIN; else go to RD.
- FIN: done = 1 for one cycle, then return to IDLE.
- Handshake rules:
  - A transfer completes on any cycle with mem_valid && mem_ready.
  - mem_addr, mem_wdata and mem_wstrb are held stable while mem_valid = 1 and mem_ready = 0.
  - mem_valid never drops before completion, except on timeout or reset.
  - mem_ready while mem_valid = 0 is ignored.
- Address arithmetic is modulo 2^32; a region crossing 0xFFFFFFFC wraps to 0.
- Timeout:
  - The watchdog restarts on every new request.
  - When it reaches TIMEOUT cycles without mem_ready: drop mem_valid, set err = 10, go to FIN.
  - Remaining words are abandoned.
- cmd_valid outside IDLE is ignored; the command is not queued.

## Timing
- Reset values:
  - state IDLE, cmd_ready = 1, busy = 0, done = 0, err = 00.
  - mem_valid = 0, mem_instr = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0.
- Reset mid-transfer: mem_valid falls asynchronously, the transfer is lost, and no done pulse is produced.
- All outputs are registered.
- Accept at edge C:
  - busy = 1 from cycle C+1 through the FIN cycle.
  - The first request is visible in cycle C+1.
- Back-to-back: the request following a completion is presented in the very next cycle, with no idle gap.
- Latency against a responder that asserts mem_ready one cycle after mem_valid:
  - 4 cycles per word.
  - done in cycle C+4·len+1.
- Error or len = 0: done in cycle C+1.

## Configuration
- PICO_DMA_FILL_EN defined:
  - Adds ports cmd_fill (in, 1) and cmd_pattern (in, 32).
  - When cmd_fill = 1 at accept: RD is skipped, every WR writes cmd_pattern, and cmd_src alignment is not checked.
  - Fill rate is 2 cycles per word with the one-cycle responder.
- PICO_DMA_FILL_EN undefined: neither port exists, and the block performs copy only.

## Structure
- Package pico_dma_pkg holds:
  - state enum (IDLE, RD, WR, FIN);
  - err codes (ERR_OK, ERR_ALIGN, ERR_TIMEOUT);
  - wstrb constants (WSTRB_RD = 0000, WSTRB_WR = 1111).
- Sub-module pico_dma_watchdog: counter of width $clog2(TIMEOUT+1), with inputs restart and run and output expired.
- The FSM and datapath stay in pico_dma_master.

## Test plan
- Copy: src 0x000, dst 0x200, len 3, memory[0..2] = 11111111 / 22222222 / 33333333.
  - Required: 6 handshakes in the order R0, W, R4, W, R8, W.
  - memory[128..130] matches; done in cycle C+13, err 00.
- Alignment: dst 0x202.
  - Required: no mem_valid, done at C+1, err 01.
- Zero length: len 0.
  - Required: no bus activity, done at C+1, err 00.
- Timeout: responder that never asserts mem_ready, TIMEOUT 8.
  - Required: mem_valid high for exactly 8 cycles then low, err 10, single done pulse.
- Reset: resetn asserted low during the second WR of a 4-word copy.
  - Required: mem_valid = 0 immediately, no done pulse, cmd_ready = 1 after release.
- Fill (with PICO_DMA_FILL_EN): dst 0x100, len 2, pattern DEADBEEF.
  - Required: two writes only, done at C+5.

Source files
------------

// File: rtl/pico_dma_pkg.sv
// pico_dma_pkg: shared types and constants for the pico_dma_master DMA engine.
//   state_e  : FSM states IDLE / RD / WR / FIN
//   ERR_*    : values reported on the err output
//   WSTRB_*  : mem_wstrb encodings for read and full-word write requests
package pico_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [3:0] WSTRB_RD = 4'b0000;
  localparam logic [3:0] WSTRB_WR = 4'b1111;

endpackage

// File: rtl/pico_dma_watchdog.sv
// pico_dma_watchdog: counts cycles a memory request has been outstanding.
//   clk      in  clock
//   resetn   in  asynchronous active-low reset
//   restart  in  a new request is presented next cycle; clears the count
//   run      in  a request is currently outstanding (mem_valid)
//   expired  out count has reached TIMEOUT-1, i.e. this is the TIMEOUT-th
//                cycle of the request; the master aborts if mem_ready is low
module pico_dma_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic resetn,
  input  logic restart,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (run && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/pico_dma_master.sv
// pico_dma_master: word-granular copy engine acting as an initiator on the
// PicoRV32 native memory interface.
//   clk, resetn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only when idle)
//   cmd_src, cmd_dst, cmd_len    word-aligned byte addresses, word count
//   busy, done, err              status: in progress, completion pulse, code
//   mem_valid/mem_ready/...      native memory request / response
// Optional feature: define PICO_DMA_FILL_EN to add cmd_fill / cmd_pattern,
// which write a constant pattern instead of copying (no reads issued).
// All outputs are registered: next values are derived from the next state.
module pico_dma_master
  import pico_dma_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
`ifdef PICO_DMA_FILL_EN
  input  logic             cmd_fill,
  input  logic [31:0]      cmd_pattern,
`endif
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic             mem_valid,
  output logic             mem_instr,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  state_e             state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         err_q, err_d;
  logic               fill_q, fill_d;
  logic               mem_valid_q, mem_valid_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [3:0]         mem_wstrb_q, mem_wstrb_d;
  logic               done_q, busy_q, cmd_ready_q;
  logic               accept, expired, restart, align_bad;
  logic               fill_cmd;
  logic [31:0]        pattern_w;

`ifdef PICO_DMA_FILL_EN
  assign fill_cmd  = cmd_fill;
  assign pattern_w = cmd_pattern;
`else
  assign fill_cmd  = 1'b0;
  assign pattern_w = '0;
`endif

  // A fill command never reads, so its source address is irrelevant.
  assign align_bad = (cmd_dst[1:0] != 2'b00) || (!fill_cmd && (cmd_src[1:0] != 2'b00));

  // Every accepted command and every completed transfer starts a fresh request.
  assign restart = accept || (mem_valid_q && mem_ready);

  pico_dma_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .restart (restart),
    .run     (mem_valid_q),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    fill_d  = fill_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          src_d  = cmd_src;
          dst_d  = cmd_dst;
          len_d  = cmd_len;
          fill_d = fill_cmd;
          err_d  = ERR_OK;
          if (fill_cmd) wdata_d = pattern_w;
          if (align_bad) begin
            state_d = FIN;
            err_d   = ERR_ALIGN;
          end else if (cmd_len == '0) begin
            state_d = FIN;
          end else begin
            state_d = fill_cmd ? WR : RD;
          end
        end
      end
      RD: begin
        if (mem_ready) begin
          wdata_d = mem_rdata;
          src_d   = src_q + 32'd4;
          state_d = WR;
        end else if (expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = FIN;
        end
      end
      WR: begin
        if (mem_ready) begin
          dst_d = dst_q + 32'd4;
          len_d = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) state_d = FIN;
          else                    state_d = fill_q ? WR : RD;
        end else if (expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs follow the next state so the request is on the port in the
    // cycle right after the decision, with no idle gap between transfers.
    mem_valid_d = (state_d == RD) || (state_d == WR);
    mem_wstrb_d = (state_d == WR) ? WSTRB_WR : WSTRB_RD;
    if (state_d == RD)      mem_addr_d = src_d;
    else if (state_d == WR) mem_addr_d = dst_d;
    else                    mem_addr_d = mem_addr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      err_q       <= ERR_OK;
      fill_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= WSTRB_RD;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      fill_q      <= fill_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      done_q      <= (state_d == FIN);
      busy_q      <= (state_d != IDLE);
      cmd_ready_q <= (state_d == IDLE);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_valid = mem_valid_q;
  assign mem_instr = 1'b0;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_pico_dma_master.sv
// Bench for pico_dma_master: a one-cycle-latency memory responder, a
// transaction-level model producing the expected request sequence and done
// timing for each command, and a per-cycle compare inside tick().
module tb_pico_dma_master;

  localparam int TO = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_src = '0;
  logic [31:0]   cmd_dst = '0;
  logic [LW-1:0] cmd_len = '0;
`ifdef PICO_DMA_FILL_EN
  logic          cmd_fill = 1'b0;
  logic [31:0]   cmd_pattern = '0;
`endif
  logic          busy, done;
  logic [1:0]    err;
  logic          mem_valid, mem_instr, mem_ready;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  pico_dma_master #(.TIMEOUT(TO), .LEN_W(LW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
`ifdef PICO_DMA_FILL_EN
    .cmd_fill    (cmd_fill),
    .cmd_pattern (cmd_pattern),
`endif
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder memory: 1024 words, address bits [11:2].
  function automatic logic [31:0] init_word(input int i);
    if (i < 3) return 32'h11111111 * (i + 1);
    return 32'hA5000000 | i;
  endfunction

  logic        ready_en = 1'b1;
  logic [31:0] mem [0:1023];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else begin
      if (mem_valid && mem_ready && mem_wstrb == 4'hF) mem[mem_addr[11:2]] <= mem_wdata;
      if (ready_en && mem_valid && !mem_ready) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[mem_addr[11:2]];
      end else begin
        mem_ready <= 1'b0;
      end
    end
  end

  // Model state
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] ref_mem [0:1023];

  int checks = 0;
  int errors = 0;
  int done_cnt, done_cyc, valid_cnt;
  logic allow_drop = 1'b0;
  logic pv = 1'b0, pr = 1'b0;
  logic [31:0] pa, pd;
  logic [3:0]  ps;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: wait for the falling edge and compare everything visible.
  task automatic tick();
    xfer_t e;
    @(negedge clk);
    if (!resetn) begin
      pv = 1'b0;
    end else begin
      if (mem_valid) begin
        valid_cnt++;
        chk("mem_instr", {31'b0, mem_instr}, 32'd0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_extra actual_addr=%h required=no_transfer", mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_addr", mem_addr, e.addr);
          chk("xfer_wstrb", {28'b0, mem_wstrb}, {28'b0, e.strb});
          if (e.strb == 4'hF) chk("xfer_wdata", mem_wdata, e.data);
        end
      end
      if (pv && !pr) begin
        if (mem_valid) begin
          chk("hold_addr", mem_addr, pa);
          chk("hold_wstrb", {28'b0, mem_wstrb}, {28'b0, ps});
          chk("hold_wdata", mem_wdata, pd);
        end else if (!allow_drop) begin
          checks++;
          errors++;
          $display("FAIL valid_drop actual=0 required=1 addr=%h", pa);
        end
      end
      pv = mem_valid;
      pr = mem_ready;
      pa = mem_addr;
      ps = mem_wstrb;
      pd = mem_wdata;
    end
  endtask

  // Model: expected request sequence and done offset (cycles after accept).
  task automatic build_model(input logic [31:0] src, input logic [31:0] dst,
                             input logic [LW-1:0] len, input logic fill,
                             input logic [31:0] pat, output int off);
    logic        bad;
    logic [31:0] as, ad, w;
    xfer_t       x;
    bad = (dst[1:0] != 2'b00) || (!fill && src[1:0] != 2'b00);
    if (bad || len == 0) begin
      off = 1;
    end else begin
      off = fill ? 2 * int'(len) + 1 : 4 * int'(len) + 1;
      for (int i = 0; i < int'(len); i++) begin
        as = src + 32'(4 * i);
        ad = dst + 32'(4 * i);
        w  = fill ? pat : ref_mem[as[11:2]];
        if (!fill) begin
          x.addr = as; x.strb = 4'h0; x.data = '0;
          exp_q.push_back(x);
        end
        x.addr = ad; x.strb = 4'hF; x.data = w;
        exp_q.push_back(x);
        ref_mem[ad[11:2]] = w;
      end
    end
  endtask

  // Offer a command at a falling edge; returns the accept edge index C.
  task automatic start_cmd(input logic [31:0] src, input logic [31:0] dst,
                           input logic [LW-1:0] len, input logic fill,
                           input logic [31:0] pat, output int c);
    cmd_src = src;
    cmd_dst = dst;
    cmd_len = len;
`ifdef PICO_DMA_FILL_EN
    cmd_fill = fill;
    cmd_pattern = pat;
`else
    if (fill || pat != 0) $display("note: fill request ignored in copy-only build");
`endif
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    done_cnt  = 0;
    valid_cnt = 0;
    tick();
    c = cyc - 1;
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
  endtask

  task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst,
                         input logic [LW-1:0] len, input logic fill,
                         input logic [31:0] pat, input logic [1:0] exp_err,
                         output int act_off);
    int   off, c;
    logic nobus, busy_bad;
    build_model(src, dst, len, fill, pat, off);
    nobus = (exp_q.size() == 0);
    start_cmd(src, dst, len, fill, pat, c);
    busy_bad = 1'b0;
    for (int k = 0; k < 400 && cyc < c + off + 3; k++) begin
      if (cyc <= c + off && busy !== 1'b1) busy_bad = 1'b1;
      tick();
    end
    act_off = (done_cnt > 0) ? done_cyc - c : -1;
    chk("done_cycle", act_off, off);
    chk("done_count", done_cnt, 1);
    chk("err", {30'b0, err}, {30'b0, exp_err});
    chk("xfers_missing", exp_q.size(), 0);
    chk("busy_during", {31'b0, busy_bad}, 32'd0);
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    if (nobus) chk("no_bus", valid_cnt, 0);
    exp_q.delete();
  endtask

  initial begin
    int off, c;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    done_cnt = 0; done_cyc = 0; valid_cnt = 0;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    tick();
    // Reset state
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {30'b0, err}, 32'd0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_instr", {31'b0, mem_instr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);

    // Basic 3-word copy
    run_cmd(32'h000, 32'h200, 3, 1'b0, 32'h0, 2'b00, off);
    chk("copy_latency_lit", off, 13);
    chk("copy_mem128", mem[128], 32'h11111111);
    chk("copy_mem129", mem[129], 32'h22222222);
    chk("copy_mem130", mem[130], 32'h33333333);

    // Single word, back-to-back command right after the previous one
    run_cmd(32'h040, 32'h080, 1, 1'b0, 32'h0, 2'b00, off);
    chk("copy1_latency_lit", off, 5);
    chk("copy1_mem32", mem[32], 32'hA5000010);

    // Misaligned destination / source
    run_cmd(32'h000, 32'h202, 3, 1'b0, 32'h0, 2'b01, off);
    chk("align_latency_lit", off, 1);
    run_cmd(32'h001, 32'h200, 1, 1'b0, 32'h0, 2'b01, off);

    // Zero length
    run_cmd(32'h000, 32'h200, 0, 1'b0, 32'h0, 2'b00, off);
    chk("zero_latency_lit", off, 1);

    // Source region wrapping past 0xFFFFFFFC
    run_cmd(32'hFFFFFFFC, 32'h300, 2, 1'b0, 32'h0, 2'b00, off);
    chk("wrap_mem192", mem[192], 32'hA50003FF);
    chk("wrap_mem193", mem[193], 32'h11111111);

    // Timeout: responder never answers
    ready_en   = 1'b0;
    allow_drop = 1'b1;
    start_cmd(32'h010, 32'h210, 2, 1'b0, 32'h0, c);
    for (int k = 0; k < 30 && cyc < c + TO + 6; k++) tick();
    chk("to_valid_cycles", valid_cnt, TO);
    chk("to_done_count", done_cnt, 1);
    chk("to_done_cycle", done_cyc - c, TO + 1);
    chk("to_err", {30'b0, err}, 32'h2);
    chk("to_valid_low", {31'b0, mem_valid}, 32'd0);
    ready_en   = 1'b0;
    allow_drop = 1'b0;
    ready_en   = 1'b1;

    // Reset during the second write of a 4-word copy
    build_model(32'h020, 32'h240, 4, 1'b0, 32'h0, off);
    start_cmd(32'h020, 32'h240, 4, 1'b0, 32'h0, c);
    for (int k = 0; k < 30 && cyc < c + 7; k++) tick();
    chk("rst_mid_wstrb", {28'b0, mem_wstrb}, 32'hF);
    chk("rst_mid_addr", mem_addr, 32'h244);
    resetn = 1'b0;
    #1;
    chk("rst_mid_valid", {31'b0, mem_valid}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    done_cnt = 0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);

`ifdef PICO_DMA_FILL_EN
    // Fill: writes only
    run_cmd(32'h003, 32'h100, 2, 1'b1, 32'hDEADBEEF, 2'b00, off);
    chk("fill_latency_lit", off, 5);
    chk("fill_valid_cycles", valid_cnt, 4);
    chk("fill_mem64", mem[64], 32'hDEADBEEF);
    chk("fill_mem65", mem[65], 32'hDEADBEEF);
`endif

    // Copy after reset still works
    run_cmd(32'h000, 32'h200, 2, 1'b0, 32'h0, 2'b00, off);
    chk("post_rst_latency_lit", off, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
